// File: rtl/key_event_gen_pkg.sv
// ============================================================================
// key_evt_pkg
// Shared types and constants for key_event_gen: FSM state encoding,
// default timing parameters and the counter-width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam int DEF_HOLD_CYCLES   = 32;
    localparam int DEF_REPEAT_CYCLES = 16;

    // Wide enough to hold the larger terminal count (value - 1).
    function automatic int cnt_w(input int hold, input int rep);
        int m;
        m = (hold > rep) ? hold : rep;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_gen_if.sv
// ============================================================================
// key_event_gen_if
// Key level in, synchronized level and single-cycle key events out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface key_event_gen_if;
    logic key_lvl;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_evt;

    modport master (
        output key_lvl,
        input  held, press_pulse, release_pulse, long_pulse, repeat_pulse, key_evt
    );

    modport slave (
        input  key_lvl,
        output held, press_pulse, release_pulse, long_pulse, repeat_pulse, key_evt
    );
endinterface

`default_nettype wire

// File: rtl/key_event_gen_sync_edge_det.sv
// ============================================================================
// sync_edge_det
// Two-flop synchronizer plus delay flop; reports level, rise and fall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s3;
    assign rise  = r_s2 & ~r_s3;
    assign fall  = ~r_s2 & r_s3;

endmodule

`default_nettype wire

// File: rtl/key_event_gen.sv
// ============================================================================
// key_event_gen
// Turns a debounced key level into press/release/long/repeat pulses.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_event_gen
    import key_evt_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
)(
    input  logic           clk,
    input  logic           rst,
    key_event_gen_if.slave bus
);

    localparam int             CNT_W     = cnt_w(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic w_level;
    logic w_rise;
    logic w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_press,   w_press_nxt;
    logic r_release, w_release_nxt;
    logic r_long,    w_long_nxt;
    logic r_repeat,  w_repeat_nxt;
    logic r_evt;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.key_lvl),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_evt     <= w_press_nxt | w_repeat_nxt;
        end
    end

    // A fall always wins over a terminal count in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = LONG;
                    w_cnt_nxt   = '0;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
`ifdef KEY_AUTO_REPEAT_EN
                    if (r_cnt == REP_LAST) begin
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.held          = w_level;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.key_evt       = r_evt;

endmodule

`default_nettype wire
